decode_sdiv_62s_23s_40_seq: RTL

- Sequential signed divider for the decoder datapath; the inverse of the encoder's pipelined 40s x 23s -> 62-bit signed multiply.
- Divides a 62-bit signed dividend (encoded product) by a 23-bit signed coefficient to recover a 40-bit signed quotient plus remainder.
- Iterative restoring algorithm on magnitudes, one quotient bit per enabled cycle, with a start/done handshake.
- Instantiated by the decode core next to its `ce`-gated pipeline.

---
 rtl/decode_sdiv_62s_23s_40_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/decode_sdiv_62s_23s_40_seq.sv
// Sequential restoring signed divider, one quotient bit per enabled cycle.
// Recovers the 40-bit factor from the encoder's 62-bit product.
module decode_sdiv_62s_23s_40_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 62,
    parameter int din1_WIDTH = 23,
    parameter int dout_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int N0 = din0_WIDTH;
    localparam int N1 = din1_WIDTH;
    localparam int W  = dout_WIDTH;
    localparam int CW = $clog2(N0);

    localparam logic [N0-1:0] QMAX =
        {{(N0-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [N0-1:0] QMIN_MAG =
        {{(N0-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] DMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] DMIN = {1'b1, {(W-1){1'b0}}};

    if (ID < 0) begin : g_id_chk
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N0-1:0]   dvd_q, dvd_d;
    logic [N1-1:0]   dsr_q, dsr_d;
    logic [N1-1:0]   prem_q, prem_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic [W-1:0]    dout_q, dout_d;
    logic [N1-1:0]   rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;

    logic [N0-1:0]   mag0;
    logic [N1-1:0]   mag1;
    logic [N1:0]     shifted;
    logic [N1:0]     diff;
    logic [N1-1:0]   rem_nx;
    logic [N0-1:0]   dvd_nx;
    logic            qneg;
    logic [N0-1:0]   qtc;
    logic [W-1:0]    sat_q;
    logic            sat_ovf;
    logic [N1-1:0]   sgn_r;

    assign mag0 = din0[N0-1] ? (~din0 + 1'b1) : din0;
    assign mag1 = din1[N1-1] ? (~din1 + 1'b1) : din1;

    // Dividend register doubles as quotient: MSB out, quotient bit in.
    assign shifted = {prem_q, dvd_q[N0-1]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign rem_nx  = diff[N1] ? shifted[N1-1:0] : diff[N1-1:0];
    assign dvd_nx  = {dvd_q[N0-2:0], ~diff[N1]};

    always_comb begin
        qneg    = s0_q ^ s1_q;
        qtc     = qneg ? (~dvd_nx + 1'b1) : dvd_nx;
        sat_q   = qtc[W-1:0];
        sat_ovf = 1'b0;
        if (!qneg && dvd_nx > QMAX) begin
            sat_q   = DMAX;
            sat_ovf = 1'b1;
        end else if (qneg && dvd_nx > QMIN_MAG) begin
            sat_q   = DMIN;
            sat_ovf = 1'b1;
        end
        sgn_r = s0_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_d  = mag0;
                        dsr_d  = mag1;
                        prem_d = '0;
                        s0_d   = din0[N0-1];
                        s1_d   = din1[N1-1];
                        cnt_d  = CW'(N0 - 1);
                        if (din1 == '0) begin
                            state_d = FIN;
                            dout_d  = din0[N0-1] ? DMIN : DMAX;
                            rem_d   = din0[N1-1:0];
                            ovf_d   = 1'b0;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    prem_d = rem_nx;
                    dvd_d  = dvd_nx;
                    cnt_d  = cnt_q - 1'b1;
                    // Results land in the output registers as FIN begins.
                    if (cnt_q == '0) begin
                        state_d = FIN;
                        dout_d  = sat_q;
                        rem_d   = sgn_r;
                        ovf_d   = sat_ovf;
                        dbz_d   = 1'b0;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == FIN);
    assign dout  = dout_q;
    assign rem   = rem_q;
    assign ovf   = ovf_q;
    assign dbz   = dbz_q;

endmodule
